// File: rtl/pipeline_pkg.sv
// Shared pipeline types: HI/LO multiply/divide opcodes, unit FSM states and step count.
package pipeline_pkg;

    localparam int MULDIV_STEPS = 32;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } muldiv_state_t;

    // Two's-complement magnitude when the operand is signed; 0x80000000 maps to itself.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 iterative datapath: unsigned shift-add multiply or restoring divide, one step per cycle.
module muldiv_datapath (
    input  logic        clk,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        is_div_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q;
    logic [32:0] add_sum;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;

    // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, quotient}.
    always_comb begin
        add_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        rem_shift = acc_q[63:31];
        rem_diff  = rem_shift - {1'b0, b_q};
        acc_d     = acc_q;
        if (load_i) begin
            acc_d = {32'd0, a_i};
        end else if (step_i) begin
            if (!is_div_i) begin
                acc_d = {add_sum, acc_q[31:1]};
            end else if (!rem_diff[32]) begin
                acc_d = {rem_diff[31:0], acc_q[30:0], 1'b1};
            end else begin
                acc_d = {acc_q[62:0], 1'b0};
            end
        end
    end

    // NOTE: no reset here -- every operation reloads these registers before they are read.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        if (load_i) begin
            b_q <= b_i;
        end
    end

    assign hi_o = acc_q[63:32];
    assign lo_o = acc_q[31:0];

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: 32-step iterative core, sign fixup, architectural HI/LO and hazard stall.
module muldiv_unit
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        hilo_use_id,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall_req
);

    muldiv_state_t state_q;
    muldiv_op_t    op_q;
    muldiv_op_t    op_in;
    logic [4:0]    cnt_q;
    logic          neg_q, rem_neg_q, div0_q;
    logic [31:0]   rs_raw_q, hi_q, lo_q;
    logic          busy_q, done_q;
    logic          accept, op_signed;
    logic [31:0]   dp_hi, dp_lo, fix_hi, fix_lo;
    logic [63:0]   prod;

    assign op_in     = muldiv_op_t'(op);
    assign op_signed = (op_in == MULT) || (op_in == DIV);
    assign accept    = start && !flush && (state_q == IDLE);

    muldiv_datapath u_datapath (
        .clk      (clk),
        .load_i   (accept),
        .step_i   (state_q == CALC),
        .is_div_i (op_q[1]),
        .a_i      (magnitude(rs_val, op_signed)),
        .b_i      (magnitude(rt_val, op_signed)),
        .hi_o     (dp_hi),
        .lo_o     (dp_lo)
    );

    always_comb begin
        prod = {dp_hi, dp_lo};
        if (neg_q) begin
            prod = ~prod + 64'd1;
        end
        fix_hi = prod[63:32];
        fix_lo = prod[31:0];
        if (op_q == DIV || op_q == DIVU) begin
            fix_lo = neg_q     ? (~dp_lo + 32'd1) : dp_lo;
            fix_hi = rem_neg_q ? (~dp_hi + 32'd1) : dp_hi;
            if (div0_q) begin
                fix_lo = 32'hFFFF_FFFF;
                fix_hi = rs_raw_q;
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= MULT;
            cnt_q     <= 5'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            rs_raw_q  <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q   <= CALC;
                        busy_q    <= 1'b1;
                        cnt_q     <= 5'd0;
                        op_q      <= op_in;
                        neg_q     <= op_signed && (rs_val[31] ^ rt_val[31]);
                        rem_neg_q <= op_signed && rs_val[31];
                        div0_q    <= (rt_val == 32'd0);
                        rs_raw_q  <= rs_val;
                    end else begin
                        if (mthi) hi_q <= rs_val;
                        if (mtlo) lo_q <= rs_val;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(MULDIV_STEPS - 1)) begin
                        state_q <= FIXUP;
                        done_q  <= 1'b1;
                    end
                end
                FIXUP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign stall_req = busy_q && hilo_use_id;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations, timing, stall, mt writes, flush and reset.
module tb_muldiv_unit;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        flush = 1'b0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        hilo_use_id = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done, stall_req;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .flush       (flush),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .hilo_use_id (hilo_use_id),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .stall_req   (stall_req)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a done pulse means HI/LO must hold the next queued result one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (done === 1'b1) begin
                @(negedge clk); #1;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done pulse, expected none");
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("%s_hi", e.name), hi, e.hi);
                    check($sformatf("%s_lo", e.name), lo, e.lo);
                end
            end
        end
    end

    // mode: 0 plain, 1 hilo_use_id from cycle 5, 2 mthi with start, 3 mtlo while busy
    task automatic do_op(input string name, input muldiv_op_t o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int mode);
        int          busy_cnt;
        int          done_cnt;
        int          done_cyc;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = 0;
        prev_hi  = m_hi;
        prev_lo  = m_lo;
        @(negedge clk);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        mthi   = (mode == 2);
        sb_q.push_back('{ehi, elo, name});
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge clk);
            start       = 1'b0;
            mthi        = 1'b0;
            mtlo        = 1'b0;
            rs_val      = 32'hA5A5_5A5A;
            rt_val      = 32'h5A5A_A5A5;
            hilo_use_id = (mode == 1 && cyc >= 5);
            if (mode == 3 && cyc == 3) begin
                mtlo   = 1'b1;
                rs_val = 32'hDEAD_BEEF;
            end
            #1;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mode == 1 && (cyc == 4 || cyc == 5 || cyc == 33 || cyc == 34))
                check($sformatf("%s_stall_c%0d", name, cyc), {31'd0, stall_req},
                      (cyc == 4 || cyc == 34) ? 32'd0 : 32'd1);
            if (mode == 2 && cyc == 1)
                check($sformatf("%s_hi_not_written", name), hi, prev_hi);
            if (mode == 3 && cyc == 4)
                check($sformatf("%s_lo_not_written", name), lo, prev_lo);
        end
        hilo_use_id = 1'b0;
        check($sformatf("%s_busy_cycles", name), busy_cnt, 32'd33);
        check($sformatf("%s_done_cycle", name), done_cyc, 32'd33);
        check($sformatf("%s_done_pulses", name), done_cnt, 32'd1);
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_cnt;
        int done_cnt;

        // Reset state, with hilo_use_id high to show stall_req stays low in IDLE.
        rst         = 1'b1;
        hilo_use_id = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("idle_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        hilo_use_id = 1'b0;

        do_op("multu_max",   MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        do_op("mult_m3x7",   MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        do_op("div_m7d2",    DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        do_op("divu_7d0",    DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 0);
        do_op("div_min_m1",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        do_op("div_m5d0",    DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
        do_op("mult_min_sq", MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        do_op("div_7dm2",    DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 2);
        do_op("multu_stall", MULTU, 32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F, 1);
        do_op("divu_100d7",  DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 3);

        // mthi in IDLE.
        @(negedge clk);
        mthi   = 1'b1;
        rs_val = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        #1;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo_held", lo, m_lo);
        m_hi = 32'h1234_5678;

        // start killed by flush: no operation, HI/LO untouched.
        @(negedge clk);
        start  = 1'b1;
        flush  = 1'b1;
        op     = MULTU;
        rs_val = 32'd2;
        rt_val = 32'd3;
        bad_cnt = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            #1;
            if (busy !== 1'b0) bad_cnt++;
        end
        check("flush_busy_cycles", bad_cnt, 32'd0);
        check("flush_hi_held", hi, m_hi);
        check("flush_lo_held", lo, m_lo);

        // Reset in CALC cycle 10, together with an mthi that reset must override.
        @(negedge clk);
        start  = 1'b1;
        op     = MULTU;
        rs_val = 32'd9;
        rt_val = 32'd9;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst    = 1'b1;
        mthi   = 1'b1;
        rs_val = 32'hFFFF_0000;
        @(negedge clk);
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        rst  = 1'b0;
        mthi = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        done_cnt = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        check("rst_mid_no_done", done_cnt, 32'd0);
        check("rst_mid_hi_after", hi, 32'd0);

        do_op("mult_after_rst", MULT, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
